neuron_sequencer: RTL and testbench

NEURON_SEQUENCER -- requirements
Module: neuron_sequencer

---
 rtl/neuron_sequencer.sv | 147 ++++++++++++++
 tb/tb_neuron_sequencer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_sequencer.sv
// Single-neuron evaluator: streams data against a synchronous weight ROM,
// accumulates with saturation, adds bias and applies a clamped ReLU.
module neuron_sequencer #(
    parameter int numInputs       = 16,
    parameter int dataWidth       = 16,
    parameter int dataFracWidth   = 10,
    parameter int weightWidth     = 16,
    parameter int weightFracWidth = 10,
    parameter int sumWidth        = 32,
    parameter int sumFracWidth    = 17,
    parameter int dataIntWidth    = 6,
    parameter int addrWidth       = (numInputs > 1) ? $clog2(numInputs) : 1
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   start,
    input  logic [sumWidth-1:0]    bias,
    input  logic [dataWidth-1:0]   in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [addrWidth-1:0]   w_addr,
    input  logic [weightWidth-1:0] w_data,
    output logic [dataWidth-1:0]   out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   busy
);

    localparam int PW    = dataWidth + weightWidth;
    localparam int SHIFT = dataFracWidth + weightFracWidth - sumFracWidth;
    localparam int LO    = sumFracWidth - dataFracWidth;

    localparam logic [addrWidth-1:0] LAST = addrWidth'(numInputs - 1);
    localparam logic [sumWidth-1:0] THRESH =
        sumWidth'(1) << (dataIntWidth - 1 + sumFracWidth);
    localparam logic [sumWidth-1:0] SMAX = {1'b0, {(sumWidth-1){1'b1}}};
    localparam logic [sumWidth-1:0] SMIN = {1'b1, {(sumWidth-1){1'b0}}};
    localparam logic [dataWidth-1:0] DMAX = {1'b0, {(dataWidth-1){1'b1}}};

    typedef enum logic [2:0] {
        IDLE, LOAD, MAC, BIAS, ACT, OUT
    } state_t;

    state_t state, state_nxt;

    logic [addrWidth-1:0] idx;
    logic [sumWidth-1:0]  acc;
    logic [sumWidth-1:0]  bias_q;
    logic [dataWidth-1:0] result;

    logic signed [PW-1:0]       full;
    logic signed [PW-1:0]       shifted;
    logic signed [sumWidth-1:0] prod;
    logic                       fire;

    assign full    = $signed(in_data) * $signed(w_data);
    assign shifted = full >>> SHIFT;
    assign prod    = sumWidth'(shifted);
    assign fire    = (state == MAC) && in_valid;

    // Widen by one bit so overflow is visible as a sign disagreement.
    function automatic logic [sumWidth-1:0] sat(
        input logic [sumWidth-1:0] a,
        input logic [sumWidth-1:0] b
    );
        logic [sumWidth:0] s;
        s = {a[sumWidth-1], a} + {b[sumWidth-1], b};
        if (s[sumWidth] != s[sumWidth-1])
            return s[sumWidth] ? SMIN : SMAX;
        return s[sumWidth-1:0];
    endfunction

    function automatic logic [dataWidth-1:0] relu(
        input logic [sumWidth-1:0] a
    );
        if (a[sumWidth-1])
            return '0;
        if (a >= THRESH)
            return DMAX;
        return a[LO+dataWidth-1:LO];
    endfunction

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (start) state_nxt = LOAD;
            LOAD: state_nxt = MAC;
            MAC:  if (fire) state_nxt = (idx == LAST) ? BIAS : LOAD;
            BIAS: state_nxt = ACT;
            ACT:  state_nxt = OUT;
            OUT:  if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        w_addr    = '0;
        unique case (state)
            IDLE: busy = 1'b0;
            LOAD: w_addr = idx;
            MAC: begin
                w_addr   = idx;
                in_ready = 1'b1;
            end
            OUT: out_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            idx    <= '0;
            acc    <= '0;
            bias_q <= '0;
            result <= '0;
        end else begin
            unique case (state)
                IDLE: if (start) begin
                    idx    <= '0;
                    acc    <= '0;
                    bias_q <= bias;
                end
                MAC: if (fire) begin
                    acc <= sat(acc, prod);
                    if (idx != LAST)
                        idx <= idx + 1'b1;
                end
                BIAS: acc <= sat(acc, bias_q);
                ACT:  result <= relu(acc);
                default: ;
            endcase
        end
    end

    assign out_data = result;

endmodule

// File: tb/tb_neuron_sequencer.sv
// Directed bench for neuron_sequencer.
// 4-input scoreboard run plus 20-input saturation run.
module tb_neuron_sequencer;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic [31:0] bias;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  w_addr;
  logic [15:0] w_data;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;

  logic        b_start;
  logic [31:0] b_bias;
  logic [15:0] b_in_data;
  logic        b_in_valid;
  logic        b_in_ready;
  logic [4:0]  b_w_addr;
  logic [15:0] b_w_data;
  logic [15:0] b_out_data;
  logic        b_out_valid;
  logic        b_out_ready;
  logic        b_busy;

  logic [15:0] dat [4];
  logic [15:0] rom [4];
  logic [15:0] sb [$];

  int total = 0;
  int bad   = 0;
  int k;

  always #5 clk = ~clk;

  always_ff @(posedge clk) w_data <= rom[w_addr];
  always_ff @(posedge clk)
    b_w_data <= (b_w_addr < 5'd20) ? 16'h7FFF : 16'h0000;

  neuron_sequencer #(.numInputs(4)) u_dut (
    .clk(clk), .resetn(resetn), .start(start), .bias(bias),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .w_addr(w_addr), .w_data(w_data),
    .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy)
  );

  neuron_sequencer #(.numInputs(20)) u_big (
    .clk(clk), .resetn(resetn), .start(b_start), .bias(b_bias),
    .in_data(b_in_data), .in_valid(b_in_valid),
    .in_ready(b_in_ready),
    .w_addr(b_w_addr), .w_data(b_w_data),
    .out_data(b_out_data), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .busy(b_busy)
  );

  task automatic chk(input string tag, input bit ok);
    total++;
    if (!ok) begin
      bad++;
      $error("FAIL %s obs=0 exp=1", tag);
    end
  endtask

  function automatic longint clamp(input longint s);
    if (s > 64'sd2147483647)  return 64'sd2147483647;
    if (s < -64'sd2147483648) return -64'sd2147483648;
    return s;
  endfunction

  function automatic logic [15:0] model(input logic [31:0] b);
    longint a, p;
    a = 0;
    for (int i = 0; i < 4; i++) begin
      p = longint'($signed(dat[i])) * longint'($signed(rom[i]));
      p = p >>> 3;
      a = clamp(a + p);
    end
    a = clamp(a + longint'($signed(b)));
    if (a < 0) return 16'h0000;
    if (a >= 64'sh40_0000) return 16'h7FFF;
    return 16'((a >>> 7) & 64'hFFFF);
  endfunction

  task automatic fill(input logic [15:0] d, input logic [15:0] w);
    for (int i = 0; i < 4; i++) begin
      dat[i] = d;
      rom[i] = w;
    end
  endtask

  task automatic eval(input logic [31:0] b, input bit rv,
                      input int hold, input bit keep,
                      input bit resume);
    logic [15:0] e, od;
    int cnt;
    bit got;
    sb.push_back(model(b));
    k = 0;
    if (!resume) begin
      @(negedge clk);
      start    = 1'b1;
      bias     = b;
      in_valid = 1'b0;
    end
    cnt = 0;
    got = 0;
    while (!got && cnt < 300) begin
      @(negedge clk);
      cnt++;
      if (!keep) start = 1'b0;
      if (out_valid) begin
        got = 1;
      end else begin
        chk("ready_busy", (in_ready & ~busy) === 1'b0);
        in_valid = rv ? 1'($urandom_range(0, 1)) : 1'b1;
        in_data  = (k < 4) ? dat[k] : 16'h0000;
        if (in_valid && in_ready) k++;
      end
    end
    in_valid = 1'b0;
    chk("timeout", got === 1'b1);
    if (!rv && !resume) chk("latency", cnt == 11);
    chk("ready_in_out", in_ready === 1'b0);
    chk("waddr_in_out", w_addr === 2'd0);
    chk("inputs_used", k == 4);
    od = out_data;
    repeat (hold) begin
      @(negedge clk);
      chk("stable", {out_valid, out_data} === {1'b1, od});
    end
    out_ready = 1'b1;
    e = sb.pop_front();
    chk("result", out_data === e);
    @(negedge clk);
    out_ready = 1'b0;
    chk("valid_drop", out_valid === 1'b0);
    chk("idle_after", busy === 1'b0);
    if (keep) begin
      @(negedge clk);
      chk("restart", busy === 1'b1);
      start = 1'b0;
    end
  endtask

  task automatic big_run(input logic [15:0] d,
                         input logic [15:0] eo,
                         input logic [31:0] ea);
    bit got;
    b_in_data = d;
    @(negedge clk);
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (b_out_valid) got = 1;
    end
    chk("big_timeout", got === 1'b1);
    chk("big_out", b_out_data === eo);
    chk("big_acc", u_big.acc === ea);
  endtask

  initial begin
    resetn      = 1'b0;
    start       = 1'b0;
    bias        = '0;
    in_data     = '0;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    b_start     = 1'b0;
    b_bias      = '0;
    b_in_data   = '0;
    b_in_valid  = 1'b1;
    b_out_ready = 1'b1;
    fill(16'h0400, 16'h0400);

    repeat (2) @(negedge clk);
    chk("rst_state",
        {busy, in_ready, out_valid, w_addr, out_data} ===
        {1'b0, 1'b0, 1'b0, 2'd0, 16'h0000});
    chk("rst_big",
        {b_busy, b_out_valid, b_out_data} === 18'h0);
    resetn = 1'b1;

    fill(16'h0400, 16'h0400);
    eval(32'h0, 0, 0, 0, 0);
    chk("unit_sum", model(32'h0) === 16'h1000);

    fill(16'h0400, 16'hFC00);
    eval(32'h0002_0000, 0, 0, 0, 0);

    fill(16'h7FFF, 16'h7FFF);
    eval(32'h0, 0, 0, 0, 0);

    dat[0] = 16'h0400; rom[0] = 16'h0800;
    dat[1] = 16'h0200; rom[1] = 16'h0400;
    dat[2] = 16'hFE00; rom[2] = 16'h0400;
    dat[3] = 16'h0C00; rom[3] = 16'h0100;
    eval(32'h0000_8000, 1, 5, 0, 0);
    eval(32'hFFFF_0000, 1, 3, 0, 0);

    fill(16'h0400, 16'h0400);
    eval(32'h0, 1, 5, 0, 0);

    @(negedge clk);
    start    = 1'b1;
    bias     = '0;
    in_valid = 1'b1;
    in_data  = dat[0];
    k = 0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready && k == 2) break;
      if (in_ready) k++;
    end
    chk("reached_idx2", {in_ready, k} === {1'b1, 32'd2});
    resetn = 1'b0;
    #1;
    chk("rst_mid",
        {busy, in_ready, out_valid, w_addr, out_data} ===
        {1'b0, 1'b0, 1'b0, 2'd0, 16'h0000});
    chk("rst_acc", u_dut.acc === 32'h0);
    in_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    eval(32'h0, 0, 0, 0, 0);

    @(negedge clk);
    start = 1'b1;
    bias  = 32'h0;
    eval(32'h0, 0, 0, 1, 1);
    eval(32'h0, 0, 0, 0, 1);

    big_run(16'h7FFF, 16'h7FFF, 32'h7FFF_FFFF);
    big_run(16'h8000, 16'h0000, 32'h8000_0000);

    chk("sb_empty", sb.size() == 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
